// File: rtl/ula_multicycle.sv
// ula_multicycle: sequential ALU with single-cycle logic/add/sub ops and
// 8-step shift-add multiply and restoring divide.
// Optional feature: define ULA_DIV_EN to compile in the DIV/MOD datapath;
// without it, ops 9 and 10 complete in one cycle as reserved ops.
module ula_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
        OP_MUL = 4'd8, OP_DIV = 4'd9, OP_MOD = 4'd10
    } op_t;

    localparam logic [3:0] LAST = 4'(WIDTH - 1);

    state_t             state_q, state_n;
    logic [3:0]         op_q, op_n;
    logic [WIDTH-1:0]   x_q, x_n;      // MUL: multiplier (shifts right); DIV: dividend -> quotient
    logic [WIDTH-1:0]   y_q, y_n;      // multiplicand / divisor
    logic [2*WIDTH-1:0] acc_q, acc_n;  // MUL partial product
    logic [3:0]         cnt_q, cnt_n;
    logic [WIDTH-1:0]   res_n;
    logic               z_n, n_n, c_n, v_n, busy_n, done_n;
    logic               is_multi;

    logic [WIDTH:0]     add_w, sub_w, mul_sum;
    logic [2*WIDTH-1:0] mul_acc;

`ifdef ULA_DIV_EN
    logic [WIDTH-1:0]   rem_q, rem_n, rem_step;
    logic [WIDTH:0]     trial, trial_sub;
    logic               q_bit;
`endif

    assign add_w   = {1'b0, a} + {1'b0, b};
    assign sub_w   = {1'b0, a} - {1'b0, b};
    // Right-shifting shift-add: high half accumulates, low half collects product bits.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (x_q[0] ? y_q : '0)};
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ULA_DIV_EN
    // Restoring divide step: bring in next dividend bit, subtract divisor if it fits.
    assign trial     = {rem_q, x_q[WIDTH-1]};
    assign trial_sub = trial - {1'b0, y_q};
    assign q_bit     = (trial >= {1'b0, y_q});
    assign rem_step  = q_bit ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
    assign is_multi  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`else
    assign is_multi  = (op == OP_MUL);
`endif

    // Registers: FSM state, iteration datapath and all outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef ULA_DIV_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            x_q     <= x_n;
            y_q     <= y_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
            result  <= res_n;
            flag_z  <= z_n;
            flag_n  <= n_n;
            flag_c  <= c_n;
            flag_v  <= v_n;
            busy    <= busy_n;
            done    <= done_n;
`ifdef ULA_DIV_EN
            rem_q   <= rem_n;
`endif
        end
    end

    // Next-state, iteration step and result/flag computation.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        x_n     = x_q;
        y_n     = y_q;
        acc_n   = acc_q;
        cnt_n   = cnt_q;
        res_n   = result;
        z_n     = flag_z;
        n_n     = flag_n;
        c_n     = flag_c;
        v_n     = flag_v;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef ULA_DIV_EN
        rem_n   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_multi) begin
                        state_n = RUN;
                        op_n    = op;
                        x_n     = a;
                        y_n     = b;
                        acc_n   = '0;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
`ifdef ULA_DIV_EN
                        rem_n   = '0;
`endif
                    end else begin
                        done_n = 1'b1;
                        res_n  = '0;
                        c_n    = 1'b0;
                        v_n    = 1'b0;
                        case (op)
                            OP_ADD: begin
                                res_n = add_w[WIDTH-1:0];
                                c_n   = add_w[WIDTH];
                                v_n   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_SUB: begin
                                res_n = sub_w[WIDTH-1:0];
                                c_n   = sub_w[WIDTH];
                                v_n   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_AND: res_n = a & b;
                            OP_OR:  res_n = a | b;
                            OP_XOR: res_n = a ^ b;
                            OP_NOT: res_n = ~a;
                            OP_SHL: begin
                                res_n = {a[WIDTH-2:0], 1'b0};
                                c_n   = a[WIDTH-1];
                            end
                            OP_SHR: begin
                                res_n = {1'b0, a[WIDTH-1:1]};
                                c_n   = a[0];
                            end
                            default: res_n = '0;
                        endcase
                    end
                end
            end
            RUN: begin
                cnt_n = cnt_q + 4'd1;
                if (op_q == OP_MUL) begin
                    acc_n = mul_acc;
                    x_n   = x_q >> 1;
                end
`ifdef ULA_DIV_EN
                else begin
                    rem_n = rem_step;
                    x_n   = {x_q[WIDTH-2:0], q_bit};
                end
`endif
                if (cnt_q == LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    c_n     = 1'b0;
                    v_n     = 1'b0;
                    res_n   = '0;
                    if (op_q == OP_MUL) begin
                        res_n = mul_acc[WIDTH-1:0];
                        c_n   = |mul_acc[2*WIDTH-1:WIDTH];
                    end
`ifdef ULA_DIV_EN
                    else begin
                        res_n = (op_q == OP_DIV) ? {x_q[WIDTH-2:0], q_bit} : rem_step;
                        v_n   = (y_q == '0);
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        if (done_n) begin
            z_n = (res_n == '0);
            n_n = res_n[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ula_multicycle.sv
// Self-checking bench for ula_multicycle: scoreboard of model results,
// popped on each done pulse; honours ULA_DIV_EN for ops 9/10.
module tb_ula_multicycle;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [7:0] result;
    logic       flag_z, flag_n, flag_c, flag_v, busy, done;

    int compared   = 0;
    int mismatched = 0;
    int done_seen  = 0;
    int done_exp   = 0;

    typedef struct {
        string      tag;
        logic [7:0] res;
        logic [3:0] flags;   // {z, n, c, v}
        int         lat;
    } exp_t;

    exp_t sb[$];

    ula_multicycle #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (done === 1'b1) done_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        logic [8:0]  s;
        logic [15:0] p;
        logic        c, v;
        logic [7:0]  r;
        bit          div_en;
`ifdef ULA_DIV_EN
        div_en = 1'b1;
`else
        div_en = 1'b0;
`endif
        c = 1'b0; v = 1'b0; r = 8'h00;
        e.lat = 0;
        case (o)
            4'd0: begin s = x + y; r = s[7:0]; c = s[8]; v = (x[7] == y[7]) && (r[7] != x[7]); end
            4'd1: begin r = x - y; c = (x < y); v = (x[7] != y[7]) && (r[7] != x[7]); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~x;
            4'd6: begin r = x << 1; c = x[7]; end
            4'd7: begin r = x >> 1; c = x[0]; end
            4'd8: begin p = x * y; r = p[7:0]; c = (p[15:8] != 0); e.lat = 8; end
            4'd9: if (div_en) begin r = (y == 0) ? 8'hFF : x / y; v = (y == 0); e.lat = 8; end
            4'd10: if (div_en) begin r = (y == 0) ? x : x % y; v = (y == 0); e.lat = 8; end
            default: r = 8'h00;
        endcase
        e.res   = r;
        e.flags = {(r == 0), r[7], c, v};
        e.tag   = $sformatf("op%0d_%h_%h", o, x, y);
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; drives start for one edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input bit push);
        if (push) sb.push_back(model(o, x, y));
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits for done (bounded), pops the scoreboard and compares.
    task automatic wait_done(input int budget, input bit poke);
        int   cyc = 0;
        int   busy_cyc = 0;
        exp_t e;
        while (done !== 1'b1 && cyc < budget) begin
            if (busy === 1'b1) busy_cyc++;
            if (poke && cyc == 2) begin start = 1'b1; op = 4'd0; a = 8'd1; b = 8'd1; end
            else if (poke && cyc == 3) start = 1'b0;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard: observed empty expected entry");
            return;
        end
        e = sb.pop_front();
        done_exp++;
        check({e.tag, "_done"},    16'(done), 16'd1);
        check({e.tag, "_result"},  16'(result), 16'(e.res));
        check({e.tag, "_zncv"},    16'({flag_z, flag_n, flag_c, flag_v}), 16'(e.flags));
        check({e.tag, "_latency"}, 16'(cyc), 16'(e.lat));
        check({e.tag, "_busycyc"}, 16'(busy_cyc), 16'(e.lat));
        check({e.tag, "_busy_at_done"}, 16'(busy), 16'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        @(negedge clock);
        @(negedge clock);
        check("reset_result", 16'(result), 16'h0000);
        check("reset_flags",  16'({flag_z, flag_n, flag_c, flag_v}), 16'h0000);
        check("reset_busy",   16'(busy), 16'd0);
        check("reset_done",   16'(done), 16'd0);
        reset = 1'b1;
        @(negedge clock);

        // ADD overflow, then confirm done is a single-cycle pulse
        issue(4'd0, 8'h7F, 8'h01, 1'b1); wait_done(4, 1'b0);
        @(negedge clock);
        check("add_done_fall", 16'(done), 16'd0);
        check("add_result_hold", 16'(result), 16'h0080);

        issue(4'd1, 8'h03, 8'h05, 1'b1); wait_done(4, 1'b0);
        issue(4'd6, 8'h81, 8'h00, 1'b1); wait_done(4, 1'b0);
        issue(4'd0, 8'hFF, 8'h01, 1'b1); wait_done(4, 1'b0);
        issue(4'd1, 8'h80, 8'h01, 1'b1); wait_done(4, 1'b0);
        issue(4'd2, 8'hF0, 8'h3C, 1'b1); wait_done(4, 1'b0);
        issue(4'd3, 8'hF0, 8'h0C, 1'b1); wait_done(4, 1'b0);
        issue(4'd4, 8'hAA, 8'hFF, 1'b1); wait_done(4, 1'b0);
        issue(4'd5, 8'h0F, 8'h00, 1'b1); wait_done(4, 1'b0);
        issue(4'd7, 8'h81, 8'h00, 1'b1); wait_done(4, 1'b0);
        issue(4'd12, 8'h55, 8'h66, 1'b1); wait_done(4, 1'b0);

        // MUL with an ignored start mid-flight, then back-to-back ADD in the done cycle
        issue(4'd8, 8'h10, 8'h11, 1'b1); wait_done(20, 1'b1);
        issue(4'd0, 8'h01, 8'h02, 1'b1); wait_done(4, 1'b0);
        issue(4'd8, 8'hFF, 8'hFF, 1'b1); wait_done(20, 1'b0);
        issue(4'd8, 8'h0D, 8'h0B, 1'b1); wait_done(20, 1'b0);

        // DIV/MOD (multi-cycle with ULA_DIV_EN, reserved otherwise)
        issue(4'd9,  8'd200, 8'd7, 1'b1); wait_done(20, 1'b0);
        issue(4'd10, 8'd200, 8'd7, 1'b1); wait_done(20, 1'b0);
        issue(4'd9,  8'h2A, 8'h00, 1'b1); wait_done(20, 1'b0);
        issue(4'd10, 8'h2A, 8'h00, 1'b1); wait_done(20, 1'b0);
        issue(4'd9,  8'h05, 8'h09, 1'b1); wait_done(20, 1'b0);

        // Reset during the 4th RUN cycle of MUL aborts it without a done
        issue(4'd8, 8'h10, 8'h11, 1'b0);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy",   16'(busy), 16'd0);
        check("abort_result", 16'(result), 16'h0000);
        check("abort_flags",  16'({flag_z, flag_n, flag_c, flag_v}), 16'h0000);
        check("abort_done",   16'(done), 16'd0);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        issue(4'd0, 8'h02, 8'h03, 1'b1); wait_done(4, 1'b0);

        repeat (3) @(negedge clock);
        check("done_pulse_count", 16'(done_seen), 16'(done_exp));
        check("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ula_multicycle.md
# ula_multicycle

Sequential 8-bit ALU for the processor datapath, sitting directly upstream of the result latch. It accepts an operation and two operands on a start strobe. Logic and add/sub ops complete in one cycle; multiply and divide iterate over 8 cycles. It presents a registered result plus flags, with a one-cycle `done` pulse that the control unit routes to the latch's `grab` input.

## Interface
- `WIDTH`, 8, operand/result width; the design is only verified at 8.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low
- `start`  in  1  begin operation; sampled only in IDLE
- `op`  in  4  operation code
- `a`  in  8  operand A
- `b`  in  8  operand B
- `result`  out  8  registered result, held until the next completion
- `flag_z`  out  1  result == 0
- `flag_n`  out  1  result[7]
- `flag_c`  out  1  carry/borrow/shift-out/mul-overflow
- `flag_v`  out  1  signed overflow or divide-by-zero
- `busy`  out  1  multi-cycle operation in progress
- `done`  out  1  one-cycle pulse: result/flags updated this cycle

## Operation
- Op codes:
  - 0 ADD
  - 1 SUB (a−b)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT a
  - 6 SHL a by 1
  - 7 SHR a by 1 (logical)
  - 8 MUL (low byte)
  - 9 DIV (quotient)
  - 10 MOD (remainder)
  - 11–15 reserved
- States:
  - IDLE: `start`=1 with op 0–7 or reserved writes result/flags and pulses `done`; stays in IDLE.
  - IDLE: `start`=1 with op 8–10 latches a, b and op, clears the iteration counter, sets `busy`, and moves to RUN.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle with a 4-bit counter.
  - RUN: on the 8th step, writes result/flags, pulses `done`, clears `busy` and returns to IDLE.
- `start` while `busy`=1 is ignored; the in-flight operands are unaffected.
- Arithmetic rules:
  - All arithmetic is unsigned 8-bit; MUL forms a 16-bit product internally.
  - Reserved ops give result 8'h00, Z=1, other flags 0, with single-cycle completion.
- Flag C:
  - ADD: carry out.
  - SUB: borrow (a<b unsigned).
  - SHL: a[7].
  - SHR: a[0].
  - MUL: product[15:8]≠0.
  - All other ops: 0.
- Flag V:
  - ADD/SUB: signed two's-complement overflow.
  - DIV/MOD: b==0.
  - All other ops: 0.
- Divide by zero runs the full 8 cycles; quotient = 8'hFF, remainder = a (natural restoring result).
- Flags and result update only on a `done` cycle; otherwise they hold.

## Timing
- Reset (`reset`=0 at an edge) forces:
  - state IDLE
  - `result`=0
  - all flags=0
  - `busy`=0, `done`=0
  - counter 0
- Reset mid-RUN aborts the operation; no `done` is issued.
- Single-cycle op: `start` sampled at edge k; `result`/flags/`done` valid after edge k; `done` falls after edge k+1.
- Multi-cycle op: `start` at edge k.
  - `busy`=1 after edges k..k+7.
  - Result and `done` appear after edge k+8, with `busy`=0 in that same cycle.
  - Latency is 8 cycles.
- A new `start` is accepted in the cycle where `done`=1 (state is already IDLE); back-to-back ops are allowed.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Configuration
- `ULA_DIV_EN` defined: DIV/MOD datapath (remainder register, subtractor) is compiled in; ops 9 and 10 behave as above.
- `ULA_DIV_EN` undefined: divider logic is absent; ops 9 and 10 behave as reserved (single-cycle, result 0, Z=1). MUL is unaffected.

## Test plan
- ADD a=8'h7F, b=8'h01 -> after 1 cycle result 8'h80, N=1, V=1, C=0, Z=0, `done` high exactly one cycle.
- SUB a=8'h03, b=8'h05 -> result 8'hFE, C=1, N=1, V=0; SHL a=8'h81 -> result 8'h02, C=1.
- MUL a=8'h10, b=8'h11 -> `busy` 8 cycles, then result 8'h10, C=1; a second `start` (ADD 1+1) during `busy` is ignored.
- DIV a=8'd200, b=8'd7 -> result 8'h1C; MOD same operands -> 8'h04; DIV a=8'h2A, b=0 -> 8'hFF, V=1; MOD a=8'h2A, b=0 -> 8'h2A, V=1.
- Reset asserted in the 4th RUN cycle of MUL -> `busy`=0, result 0, flags 0, no `done`; next ADD 2+3 -> 8'h05 after 1 cycle.
- Without `ULA_DIV_EN`: op 9 with a=8'd200, b=8'd7 -> after 1 cycle result 8'h00, Z=1, `busy` never asserted.
